// File: rtl/mul_datapath_ctl.sv
// Sequential unsigned multiplier: Prod = A * B by B repeated additions of A.
// Operands arrive byte-serially on Data_in (A with start, B on the following cycle).
module mul_datapath_ctl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   Data_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Prod
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOADB = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   prod_reg;

    assign Prod = prod_reg;

    // busy and done are registered alongside the state so they track it exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            a_reg    <= '0;
            cnt      <= '0;
            acc      <= '0;
            prod_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= Data_in;
                        busy  <= 1'b1;
                        state <= LOADB;
                    end
                end
                LOADB: begin
                    cnt   <= Data_in;
                    acc   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    if (cnt != '0) begin
                        acc <= acc + {{WIDTH{1'b0}}, a_reg};
                        cnt <= cnt - WIDTH'(1);
                    end else begin
                        prod_reg <= acc;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_datapath_ctl.sv
// Directed bench for mul_datapath_ctl: hand-computed products and edge counts.
module tb_mul_datapath_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  Data_in;
    logic        busy;
    logic        done;
    logic [15:0] Prod;

    int total = 0;
    int bad   = 0;

    mul_datapath_ctl #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Data_in (Data_in),
        .busy    (busy),
        .done    (done),
        .Prod    (Prod)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 time unit after edge 1 (the B capture edge).
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        start   = 1'b1;
        Data_in = a;
        tick();
        start   = 1'b0;
        Data_in = b;
        tick();
        Data_in = 8'($urandom);
    endtask

    task automatic wait_done(input int limit, input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int exp_prod, input int exp_edges);
        int n;
        start_op(a, b);
        wait_done(400, 1, n);
        chk({tag, "_edges"}, 32'(n), 32'(exp_edges));
        chk({tag, "_prod"}, 32'(Prod), 32'(exp_prod));
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
        chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
        chk({tag, "_prod_hold"}, 32'(Prod), 32'(exp_prod));
    endtask

    initial begin
        int n;
        int dcount;
        int first;
        int second;
        logic saw_done;

        rst     = 1'b1;
        start   = 1'b0;
        Data_in = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prod", 32'(Prod), 32'd0);
        rst = 1'b0;
        tick();

        do_op("mul_13x11", 8'd13, 8'd11, 143, 13);
        do_op("mul_0x200", 8'd0, 8'd200, 0, 202);
        do_op("mul_200x0", 8'd200, 8'd0, 0, 2);
        do_op("mul_255x255", 8'd255, 8'd255, 65025, 257);

        // start pulse with garbage operand while busy must be ignored
        start_op(8'd5, 8'd10);
        tick();
        tick();
        tick();
        start   = 1'b1;
        Data_in = 8'hFF;
        tick();
        start   = 1'b0;
        wait_done(400, 5, n);
        chk("busy_start_edges", 32'(n), 32'd12);
        chk("busy_start_prod", 32'(Prod), 32'd50);
        tick();
        tick();
        tick();
        chk("busy_start_no_requeue", 32'(busy), 32'd0);

        // start held high: done at edges 6 and 14 (one IDLE cycle between ops)
        dcount = 0;
        first  = -1;
        second = -1;
        start  = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            Data_in = (k == 1 || k == 9) ? 8'd4 : 8'd3;
            if (k == 15) start = 1'b0;
            tick();
            if (done === 1'b1) begin
                dcount++;
                if (dcount == 1) begin
                    first = k;
                    chk("b2b_prod1", 32'(Prod), 32'd12);
                end else if (dcount == 2) begin
                    second = k;
                    chk("b2b_prod2", 32'(Prod), 32'd12);
                end
            end
        end
        chk("b2b_count", 32'(dcount), 32'd2);
        chk("b2b_first", 32'(first), 32'd6);
        chk("b2b_spacing", 32'(second - first), 32'd8);
        tick();
        chk("b2b_idle", 32'(busy), 32'd0);

        do_op("mul_6x7", 8'd6, 8'd7, 42, 9);
        for (int i = 0; i < 50; i++) begin
            Data_in = 8'($urandom);
            tick();
            chk("hold_done", 32'(done), 32'd0);
            chk("hold_prod", 32'(Prod), 32'd42);
        end

        // reset mid-ADD abandons the operation and clears Prod
        start_op(8'd9, 8'd100);
        for (int i = 0; i < 20; i++) tick();
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_prod", 32'(Prod), 32'd0);
        tick();
        rst = 1'b0;
        chk("mid_rst2_prod", 32'(Prod), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("mid_rst_no_done", 32'(saw_done), 32'd0);
        chk("mid_rst_idle", 32'(busy), 32'd0);

        do_op("mul_7x9", 8'd7, 8'd9, 63, 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
